// File: rtl/multi_domain_clk_rst_ctrl.sv
// multi_domain_clk_rst_ctrl: per-domain FLL clock switch, clock enable and reset release sequencer
// Ports:
//   clk_i, rst_i             reference clock, synchronous active-high reset
//   lock_i                   raw asynchronous FLL lock flags, one per domain
//   cfg_req_i .. cfg_data_i  req/ack config port; address is {domain, reg}, reg 0 = CTRL, 1 = STATUS
//   cfg_ack_o, cfg_r_data_o  one-cycle acknowledge with read data
//   clk_sel_o                1 = reference clock, 0 = FLL clock
//   clk_en_o                 domain clock gate enable
//   rstn_o                   active-low domain reset
module multi_domain_clk_rst_ctrl #(
    parameter int NB_DOMAINS    = 3,
    parameter int CNT_WIDTH     = 8,
    parameter int SWITCH_CYCLES = 4,
    parameter int HOLD_CYCLES   = 8,
    parameter int DEFAULT_DELAY = 16,
    parameter bit ORDERED       = 1'b1,
    localparam int AW           = $clog2(NB_DOMAINS) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NB_DOMAINS-1:0] lock_i,
    input  logic                  cfg_req_i,
    input  logic                  cfg_wrn_i,
    input  logic [AW-1:0]         cfg_add_i,
    input  logic [31:0]           cfg_data_i,
    output logic                  cfg_ack_o,
    output logic [31:0]           cfg_r_data_o,
    output logic [NB_DOMAINS-1:0] clk_sel_o,
    output logic [NB_DOMAINS-1:0] clk_en_o,
    output logic [NB_DOMAINS-1:0] rstn_o
);
    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_SWITCH = 3'd1,
        ST_DELAY  = 3'd2,
        ST_RUN    = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

    localparam logic [CNT_WIDTH-1:0] SW_LOAD   = CNT_WIDTH'(SWITCH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LOAD = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DLY_RST   = CNT_WIDTH'(DEFAULT_DELAY);

    state_e                state_q [NB_DOMAINS];
    state_e                state_d [NB_DOMAINS];
    logic [CNT_WIDTH-1:0]  cnt_q   [NB_DOMAINS];
    logic [CNT_WIDTH-1:0]  cnt_d   [NB_DOMAINS];
    logic [CNT_WIDTH-1:0]  delay_q [NB_DOMAINS];
    logic [CNT_WIDTH-1:0]  delay_d [NB_DOMAINS];
    logic [31:0]           ctrl_rd [NB_DOMAINS];
    logic [31:0]           stat_rd [NB_DOMAINS];
    logic [NB_DOMAINS-1:0] sync_q, lock_s_q, force_q, force_d, wr_sel, prev_ok;
    logic                  ack_q;
    logic [31:0]           rdata_q, rdata_d;
    logic [AW-1:0]         idx;
    logic                  accept, idx_ok, wr_ctrl, rd_en;
    logic                  unused_data;

    // No re-accept during the ack cycle even if the requester still holds req.
    assign accept       = cfg_req_i & ~ack_q;
    assign idx          = cfg_add_i >> 1;
    assign idx_ok       = int'(idx) < NB_DOMAINS;
    assign wr_ctrl      = accept & ~cfg_wrn_i & ~cfg_add_i[0] & idx_ok;
    assign rd_en        = accept & cfg_wrn_i & idx_ok;
    assign unused_data  = ^cfg_data_i;
    assign cfg_ack_o    = ack_q;
    assign cfg_r_data_o = rdata_q;

    genvar g;
    for (g = 0; g < NB_DOMAINS; g++) begin : g_dom
        assign wr_sel[g] = wr_ctrl && int'(idx) == g;
        // Ordered bring-up: a domain may only start or stay up while its predecessor runs.
        if (g == 0 || !ORDERED) begin : g_free
            assign prev_ok[g] = 1'b1;
        end else begin : g_chain
            assign prev_ok[g] = state_q[g-1] == ST_RUN;
        end
        assign clk_sel_o[g] = state_q[g] == ST_WAIT || force_q[g];
        assign clk_en_o[g]  = state_q[g] != ST_WAIT && state_q[g] != ST_SWITCH;
        assign rstn_o[g]    = state_q[g] == ST_RUN;
        assign ctrl_rd[g]   = {14'd0, force_q[g], 1'b0, 16'(delay_q[g])};
        assign stat_rd[g]   = {26'd0, rstn_o[g], clk_sel_o[g], lock_s_q[g], state_q[g]};
    end

    always_comb begin
        force_d = force_q;
        rdata_d = '0;
        for (int i = 0; i < NB_DOMAINS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i] - 1'b1;
            delay_d[i] = wr_sel[i] ? cfg_data_i[CNT_WIDTH-1:0] : delay_q[i];
            if (wr_sel[i]) force_d[i] = cfg_data_i[17];
            if (rd_en && int'(idx) == i) rdata_d = cfg_add_i[0] ? stat_rd[i] : ctrl_rd[i];
            // Lock loss or predecessor drop wins over any pending soft reset.
            if (state_q[i] != ST_WAIT && !(lock_s_q[i] && prev_ok[i])) begin
                state_d[i] = ST_WAIT;
            end else begin
                case (state_q[i])
                    ST_WAIT: if (lock_s_q[i] && prev_ok[i]) begin
                        state_d[i] = ST_SWITCH;
                        cnt_d[i]   = SW_LOAD;
                    end
                    ST_SWITCH, ST_HOLD: if (cnt_q[i] == '0) begin
                        state_d[i] = ST_DELAY;
                        cnt_d[i]   = delay_q[i];
                    end
                    ST_DELAY: if (cnt_q[i] == '0) state_d[i] = ST_RUN;
                    ST_RUN: if (wr_sel[i] && cfg_data_i[16]) begin
                        state_d[i] = ST_HOLD;
                        cnt_d[i]   = HOLD_LOAD;
                    end
                    default: state_d[i] = ST_WAIT;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            lock_s_q <= '0;
            force_q  <= '0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            state_q  <= '{default: ST_WAIT};
            cnt_q    <= '{default: '0};
            delay_q  <= '{default: DLY_RST};
        end else begin
            sync_q   <= lock_i;
            lock_s_q <= sync_q;
            force_q  <= force_d;
            ack_q    <= accept;
            rdata_q  <= rdata_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            delay_q  <= delay_d;
        end
    end
endmodule

// File: tb/tb_multi_domain_clk_rst_ctrl.sv
// tb_multi_domain_clk_rst_ctrl: directed bring-up, soft reset, lock loss and config checks with a read scoreboard
module tb_multi_domain_clk_rst_ctrl;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [2:0]  lock_i = 3'b111;
    logic        cfg_req = 1'b0;
    logic        cfg_wrn = 1'b0;
    logic [2:0]  cfg_add = '0;
    logic [31:0] cfg_data = '0;
    logic        cfg_ack_o;
    logic [31:0] cfg_r_data_o;
    logic [2:0]  clk_sel_o, clk_en_o, rstn_o;

    typedef struct {
        bit          rd;
        logic [31:0] d;
        string       nm;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   passed = 0;
    int   total = 0;
    int   cyc = 0;
    int   base = 0;

    multi_domain_clk_rst_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .lock_i      (lock_i),
        .cfg_req_i   (cfg_req),
        .cfg_wrn_i   (cfg_wrn),
        .cfg_add_i   (cfg_add),
        .cfg_data_i  (cfg_data),
        .cfg_ack_o   (cfg_ack_o),
        .cfg_r_data_o(cfg_r_data_o),
        .clk_sel_o   (clk_sel_o),
        .clk_en_o    (clk_en_o),
        .rstn_o      (rstn_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        total++;
        if (act === ex) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, act, ex, cyc - base);
    endtask

    task automatic chk_o(input string nm, input logic [2:0] act, input logic [2:0] ex);
        chk(nm, {29'd0, act}, {29'd0, ex});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic at(input int n);
        if (cyc - base > n) chk("schedule", cyc - base, n);
        while (cyc - base < n) step();
    endtask

    task automatic cfg(input bit rd, input logic [2:0] a, input logic [31:0] d, input logic [31:0] ex, input string nm);
        int lat = 0;
        if (cfg_ack_o) step();
        sb.push_back('{rd, ex, nm});
        cfg_req  = 1'b1;
        cfg_wrn  = rd;
        cfg_add  = a;
        cfg_data = d;
        do begin
            step();
            lat++;
        end while (!cfg_ack_o && lat < 4);
        cfg_req = 1'b0;
        chk({nm, "_ack_lat"}, lat, 1);
    endtask

    always @(negedge clk) begin
        if (!rst_i && cfg_ack_o) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_ack: got ack=1 expected ack=0 (no request outstanding)");
            end else begin
                e = sb.pop_front();
                if (e.rd) chk(e.nm, cfg_r_data_o, e.d);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        chk_o("rst_sel", clk_sel_o, 3'b111);
        chk_o("rst_en", clk_en_o, 3'b000);
        chk_o("rst_rstn", rstn_o, 3'b000);
        chk("rst_ack", {31'd0, cfg_ack_o}, 0);
        chk("rst_rdata", cfg_r_data_o, 0);
        rst_i = 1'b0;
        base = cyc;
        cfg(1'b0, 3'b010, 32'h0, 32'h0, "wr_d1_delay0");
        at(2);   chk_o("e2_sel", clk_sel_o, 3'b111);
        at(3);   chk_o("e3_sel", clk_sel_o, 3'b110); chk_o("e3_en", clk_en_o, 3'b000);
        at(6);   chk_o("e6_en", clk_en_o, 3'b000);
        at(7);   chk_o("e7_en", clk_en_o, 3'b001); chk_o("e7_rstn", rstn_o, 3'b000);
        at(23);  chk_o("e23_rstn", rstn_o, 3'b000);
        at(24);  chk_o("e24_rstn", rstn_o, 3'b001); chk_o("e24_sel", clk_sel_o, 3'b110);
        at(25);  chk_o("e25_sel", clk_sel_o, 3'b100);
        at(29);  chk_o("e29_en", clk_en_o, 3'b011); chk_o("e29_rstn", rstn_o, 3'b001);
        at(30);  chk_o("e30_rstn", rstn_o, 3'b011);
        at(51);  chk_o("e51_rstn", rstn_o, 3'b011);
        at(52);  chk_o("e52_rstn", rstn_o, 3'b111);
        cfg(1'b1, 3'b010, 32'h0, 32'h0, "rd_ctrl_d1");
        cfg(1'b1, 3'b000, 32'h0, 32'h10, "rd_ctrl_d0");
        cfg(1'b0, 3'b100, 32'h20010, 32'h0, "wr_force_d2");
        chk_o("force_sel", clk_sel_o, 3'b100); chk_o("force_en", clk_en_o, 3'b111);
        cfg(1'b1, 3'b100, 32'h0, 32'h20010, "rd_ctrl_d2");
        cfg(1'b0, 3'b100, 32'h10, 32'h0, "wr_unforce_d2");
        chk_o("unforce_sel", clk_sel_o, 3'b000);
        at(64);
        cfg(1'b0, 3'b000, 32'h10010, 32'h0, "wr_soft_d0");
        at(65);  chk_o("s65_rstn", rstn_o, 3'b110); chk_o("s65_sel", clk_sel_o, 3'b000); chk_o("s65_en", clk_en_o, 3'b111);
        at(66);  chk_o("s66_sel", clk_sel_o, 3'b010); chk_o("s66_en", clk_en_o, 3'b101);
        at(67);  chk_o("s67_sel", clk_sel_o, 3'b110); chk_o("s67_en", clk_en_o, 3'b001);
        cfg(1'b1, 3'b001, 32'h0, 32'h0c, "rd_stat_hold");
        at(72);  chk_o("s72_rstn", rstn_o, 3'b000); chk_o("s72_en", clk_en_o, 3'b001);
        at(89);  chk_o("s89_rstn", rstn_o, 3'b000);
        at(90);  chk_o("s90_rstn", rstn_o, 3'b001);
        at(95);  chk_o("s95_en", clk_en_o, 3'b011); chk_o("s95_rstn", rstn_o, 3'b001);
        at(96);  chk_o("s96_rstn", rstn_o, 3'b011);
        at(117); chk_o("s117_rstn", rstn_o, 3'b011);
        at(118); chk_o("s118_rstn", rstn_o, 3'b111);
        lock_i = 3'b011;
        at(120); chk_o("l120_sel", clk_sel_o, 3'b000); chk_o("l120_rstn", rstn_o, 3'b111);
        at(121); chk_o("l121_sel", clk_sel_o, 3'b100); chk_o("l121_en", clk_en_o, 3'b011); chk_o("l121_rstn", rstn_o, 3'b011);
        lock_i = 3'b111;
        at(123); chk_o("l123_sel", clk_sel_o, 3'b100);
        at(124); chk_o("l124_sel", clk_sel_o, 3'b000); chk_o("l124_en", clk_en_o, 3'b011);
        at(128); chk_o("l128_en", clk_en_o, 3'b111);
        at(144); chk_o("l144_rstn", rstn_o, 3'b011);
        at(145); chk_o("l145_rstn", rstn_o, 3'b111);
        lock_i = 3'b110;
        at(147);
        cfg(1'b0, 3'b000, 32'h10010, 32'h0, "wr_soft_lockloss");
        chk_o("ll_sel", clk_sel_o, 3'b001); chk_o("ll_en", clk_en_o, 3'b110); chk_o("ll_rstn", rstn_o, 3'b110);
        cfg(1'b1, 3'b001, 32'h0, 32'h10, "rd_stat_wait");
        cfg(1'b1, 3'b110, 32'h0, 32'h0, "rd_bad_ctrl");
        cfg(1'b0, 3'b110, 32'h10010, 32'h0, "wr_bad_idx");
        cfg(1'b1, 3'b111, 32'h0, 32'h0, "rd_bad_stat");
        lock_i = 3'b111;
        base = cyc;
        at(18);  chk_o("r18_en", clk_en_o, 3'b001); chk_o("r18_rstn", rstn_o, 3'b000);
        rst_i = 1'b1;
        lock_i = 3'b000;
        at(19);
        chk_o("r19_sel", clk_sel_o, 3'b111); chk_o("r19_en", clk_en_o, 3'b000); chk_o("r19_rstn", rstn_o, 3'b000);
        chk("r19_ack", {31'd0, cfg_ack_o}, 0); chk("r19_rdata", cfg_r_data_o, 0);
        rst_i = 1'b0;
        cfg(1'b1, 3'b001, 32'h0, 32'h10, "rd_stat_after_rst");
        cfg(1'b1, 3'b010, 32'h0, 32'h10, "rd_ctrl_d1_after_rst");
        step();
        step();
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
